// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, fixed WIDTH-cycle latency.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   input  logic             mf_req,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CW      = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             special_q, special_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic               accept, signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0]   step_hi, step_lo, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod_mag, prod_res;

   assign busy  = (state_q == S_RUN);
   assign stall = busy & (op_valid | mf_req) & ~flush;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

   // Iteration runs on magnitudes; the sign is re-applied on the completion edge.
   always_comb begin : operand_prep
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = signed_op & src_a[WIDTH-1];
      b_neg     = signed_op & src_b[WIDTH-1];
      a_mag     = a_neg ? -src_a : src_a;
      b_mag     = b_neg ? -src_b : src_b;
   end

   // Multiply: acc_hi is the running partial sum, acc_lo shifts out the multiplier.
   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   always_comb begin : iterate
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
      div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, m_q};
      if (special_q) begin
         step_hi = acc_hi_q;
         step_lo = acc_lo_q;
      end else if (is_div_q) begin
         step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
      prod_mag = {step_hi, step_lo};
      prod_res = neg_lo_q ? -prod_mag : prod_mag;
      if (special_q) begin
         res_hi = step_hi;
         res_lo = step_lo;
      end else if (is_div_q) begin
         res_hi = neg_hi_q ? -step_hi : step_hi;
         res_lo = neg_lo_q ? -step_lo : step_lo;
      end else begin
         res_hi = prod_res[2*WIDTH-1:WIDTH];
         res_lo = prod_res[WIDTH-1:0];
      end
   end

   always_comb begin : next_state
      // NOTE: every _d starts from its hold value so no branch can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      special_d = special_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      m_d       = m_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      accept    = op_valid & ~busy & ~flush;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  OP_MULT, OP_MULTU: begin
                     state_d   = S_RUN;
                     cnt_d     = '0;
                     is_div_d  = 1'b0;
                     special_d = 1'b0;
                     acc_hi_d  = '0;
                     acc_lo_d  = b_mag;
                     m_d       = a_mag;
                     neg_lo_d  = a_neg ^ b_neg;
                     neg_hi_d  = 1'b0;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d   = S_RUN;
                     cnt_d     = '0;
                     is_div_d  = 1'b1;
                     special_d = 1'b0;
                     acc_hi_d  = '0;
                     acc_lo_d  = a_mag;
                     m_d       = b_mag;
                     neg_lo_d  = a_neg ^ b_neg;
                     neg_hi_d  = a_neg;
                     // Special results are preloaded and simply held for the full latency.
                     if (src_b == '0) begin
                        special_d = 1'b1;
                        acc_hi_d  = src_a;
                        acc_lo_d  = '1;
                     end else if (op == OP_DIV && src_a == MIN_NEG && src_b == '1) begin
                        special_d = 1'b1;
                        acc_hi_d  = '0;
                        acc_lo_d  = src_a;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_hi_d = step_hi;
               acc_lo_d = step_lo;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  hi_d    = res_hi;
                  lo_d    = res_lo;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         special_q <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         m_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         special_q <= special_d;
         neg_lo_q  <= neg_lo_d;
         neg_hi_q  <= neg_hi_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         m_q       <= m_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit (WIDTH=32): transaction-level reference model checked every
// cycle, directed cases with literal results, then a randomized phase.
module tb_muldiv_hilo_unit;

   localparam int W = 32;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         op_valid = 1'b0;
   logic [2:0]   op       = 3'd0;
   logic [W-1:0] src_a    = '0;
   logic [W-1:0] src_b    = '0;
   logic         flush    = 1'b0;
   logic         mf_req   = 1'b0;
   logic         busy, stall, done;
   logic [W-1:0] hi, lo;

   muldiv_hilo_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .mf_req(mf_req), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of a mul/div op as {hi, lo}, straight from the arithmetic rules.
   function automatic logic [63:0] ref_fn(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint     sp;
      logic [63:0] up;
      int         sa, sb;
      logic [31:0] qh, ql;
      sa = a;
      sb = b;
      case (f)
         3'd0: begin sp = longint'(sa) * longint'(sb); return 64'(sp); end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
            ql = sa / sb;
            qh = sa % sb;
            return {qh, ql};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Reference model: accepted op results appear exactly W edges after acceptance.
   logic         m_busy = 1'b0, m_done = 1'b0, m_acc = 1'b0;
   int           m_left = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   logic [63:0]  m_res = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_acc <= 1'b0; m_left <= 0;
         m_hi   <= '0;   m_lo   <= '0;   m_res <= '0;
      end else begin
         m_done <= 1'b0;
         m_acc  <= 1'b0;
         if (m_busy) begin
            if (flush) begin
               m_busy <= 1'b0;
            end else if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_hi   <= m_res[63:32];
               m_lo   <= m_res[31:0];
            end else begin
               m_left <= m_left - 1;
            end
         end else if (op_valid && !flush) begin
            m_acc <= 1'b1;
            case (op)
               3'd4: m_hi <= src_a;
               3'd5: m_lo <= src_a;
               3'd0, 3'd1, 3'd2, 3'd3: begin
                  m_res  <= ref_fn(op, src_a, src_b);
                  m_busy <= 1'b1;
                  m_left <= W;
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", {63'd0, busy}, {63'd0, m_busy});
         check("done", {63'd0, done}, {63'd0, m_done});
         check("hi", {32'd0, hi}, {32'd0, m_hi});
         check("lo", {32'd0, lo}, {32'd0, m_lo});
         check("stall", {63'd0, stall}, {63'd0, m_busy & (op_valid | mf_req) & ~flush});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int waited);
      op_valid = 1'b1; op = f; src_a = a; src_b = b; waited = 0;
      do begin
         tick();
         waited++;
      end while (!m_acc && waited < 100);
      op_valid = 1'b0;
      if (!m_acc) begin
         checks++; errors++;
         $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", f, waited);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!m_done && n < 100) begin
         tick();
         n++;
      end
      if (!m_done) begin
         checks++; errors++;
         $display("FAIL done_timeout: no completion after %0d cycles", n);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom_range(20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int w;
      int n;

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset hi", {32'd0, hi}, 64'd0);
      check("reset lo", {32'd0, lo}, 64'd0);

      // MULT -3 * 5 with latency measured from the accept edge
      issue(3'd0, 32'hFFFF_FFFD, 32'd5, w);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("mult latency", 64'(n), 64'd32);
      check("mult hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      check("mult lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);

      // MULTU max*max with an MTLO held waiting; accepted the edge after completion
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
      op_valid = 1'b1; op = 3'd5; src_a = 32'h0000_CAFE; src_b = 32'd3;
      repeat (3) tick();
      check("stall during run", {63'd0, stall}, 64'd1);
      wait_done();
      check("multu hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
      check("multu lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
      tick();
      op_valid = 1'b0;
      check("held mtlo lo", {32'd0, lo}, 64'h0000_0000_0000_CAFE);

      issue(3'd2, 32'hFFFF_FFF9, 32'd2, w);
      wait_done();
      check("div lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
      check("div hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

      issue(3'd3, 32'd7, 32'd0, w);
      wait_done();
      check("divu0 lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
      check("divu0 hi", {32'd0, hi}, 64'd7);

      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, w);
      wait_done();
      check("divovf lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
      check("divovf hi", {32'd0, hi}, 64'd0);

      issue(3'd4, 32'h1234, 32'd0, w);
      issue(3'd5, 32'h5678, 32'd0, w);
      check("mthi hi", {32'd0, hi}, 64'h1234);
      check("mtlo lo", {32'd0, lo}, 64'h5678);
      check("mt busy", {63'd0, busy}, 64'd0);

      // MULT 6*7 squashed at its tenth cycle
      issue(3'd0, 32'd6, 32'd7, w);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush busy", {63'd0, busy}, 64'd0);
      check("flush done", {63'd0, done}, 64'd0);
      check("flush hi", {32'd0, hi}, 64'h1234);
      check("flush lo", {32'd0, lo}, 64'h5678);
      issue(3'd1, 32'd3, 32'd4, w);
      check("accept after flush", 64'(w), 64'd1);
      wait_done();
      check("multu 3*4 lo", {32'd0, lo}, 64'd12);
      check("multu 3*4 hi", {32'd0, hi}, 64'd0);

      // flush held on the completion edge suppresses the write
      issue(3'd1, 32'd9, 32'd9, w);
      repeat (31) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("late flush done", {63'd0, done}, 64'd0);
      check("late flush lo", {32'd0, lo}, 64'd12);

      // flush beats a simultaneous MTHI
      op_valid = 1'b1; op = 3'd4; src_a = 32'hBEEF; flush = 1'b1;
      tick();
      op_valid = 1'b0; flush = 1'b0;
      check("flush vs mthi", {32'd0, hi}, 64'd0);

      issue(3'd6, 32'd1, 32'd1, w);
      issue(3'd7, 32'd1, 32'd1, w);
      check("reserved busy", {63'd0, busy}, 64'd0);
      check("reserved lo", {32'd0, lo}, 64'd12);

      // asynchronous reset in the middle of a DIVU
      issue(3'd3, 32'd1000, 32'd3, w);
      repeat (14) tick();
      #1 rst_n = 1'b0;
      #1;
      check("async rst busy", {63'd0, busy}, 64'd0);
      check("async rst hi", {32'd0, hi}, 64'd0);
      check("async rst lo", {32'd0, lo}, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      issue(3'd3, 32'd100, 32'd7, w);
      wait_done();
      check("divu 100/7 lo", {32'd0, lo}, 64'd14);
      check("divu 100/7 hi", {32'd0, hi}, 64'd2);

      // free-running random traffic; the per-cycle compare does the checking
      for (int i = 0; i < 4000; i++) begin
         op_valid = ($urandom_range(9) < 3);
         op       = 3'($urandom_range(7));
         src_a    = pick();
         src_b    = pick();
         flush    = ($urandom_range(39) == 0);
         mf_req   = 1'($urandom_range(1));
         tick();
      end
      op_valid = 1'b0; flush = 1'b0; mf_req = 1'b0;
      repeat (40) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
